// File: rtl/data_mem_responder.sv
// Word-addressed data memory. It takes one request at a time, waits a
// programmable number of cycles, then holds the response until the
// initiator accepts it.
//
// state | meaning
// IDLE  | ready for a request (req_ready_o=1)
// BUSY  | request latched, wait counter running; access on terminal count
// RESP  | response presented, held stable until resp_ready_i
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          DEPTH = int'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             req_hs;
  logic             mem_we;
  logic             legal;
  logic [31:0]      word_idx;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;

  // The full 30-bit word index is range-checked so high address bits never alias.
  assign word_idx = {2'b00, addr_q[31:2]};
  assign legal    = (addr_q[1:0] == 2'b00) && (word_idx < DEPTH_WORDS);
  assign idx      = addr_q[IDX_W+1:2];
  assign rd_word  = mem_q[idx];
  assign req_hs   = req_valid_i & req_ready_o;

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, handshake outputs, counter and response data.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is withheld while reset is asserted.
        req_ready_o = ~rst_i;
        if (req_valid_i && !rst_i) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = legal & we_q;
          rdata_d = (legal && !we_q) ? rd_word : 32'd0;
          err_d   = ~legal;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and registered datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (req_hs) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

  // Memory array; reset clears every word, so an aborted store can never land.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

endmodule
